change_dispenser: RTL and testbench

Pays out change as physical coins. Given a change amount in cents, it issues one coin request at a time to the coin-tube mechanism, largest denomination first, skipping empty or jammed tubes. It sits on the output side of the vending machine, downstream of the coin-acceptance and price logic that computes change. It reports completion, any unpaid remainder, and tube faults.

---
 rtl/change_dispenser_if.sv | 29 ++
 rtl/change_dispenser.sv | 159 +++++++++++++++
 tb/tb_change_dispenser.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Signal bundle between the change computation logic and the coin dispenser.
// The dispenser takes the slave side; the change source (or bench) takes master.
interface change_dispenser_if #(
  parameter int AMT_W = 11
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             abort;
  logic [5:0]       tubeEmpty;
  logic             coinAck;
  logic             coinReq;
  logic [5:0]       coinSel;
  logic             busy;
  logic             done;
  logic             shortfall;
  logic [AMT_W-1:0] remaining;
  logic [7:0]       coinCount;
  logic [5:0]       jammed;

  modport master (
    output start, amount, abort, tubeEmpty, coinAck,
    input  coinReq, coinSel, busy, done, shortfall, remaining, coinCount, jammed
  );

  modport slave (
    input  start, amount, abort, tubeEmpty, coinAck,
    output coinReq, coinSel, busy, done, shortfall, remaining, coinCount, jammed
  );
endinterface

// File: rtl/change_dispenser.sv
// Pays out change one coin at a time, largest denomination first, skipping
// empty or jammed tubes. Reports remainder, coin count and jammed tubes.
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | pick largest eligible coin, or finish
// REQ    | coinReq held until ack or timeout
// GAP    | mandatory idle between coin requests
// DONE   | one-cycle completion, publish results
module change_dispenser #(
  parameter int AMT_W       = 11,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);

  localparam int TMAX  = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W = $clog2(TMAX + 1);
  localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SELECT, REQ, GAP, DONE} state_t;

  state_t           state, stateNext;
  logic [AMT_W-1:0] rem, remNext;
  logic [5:0]       selReg, selNext;
  logic [CNT_W-1:0] tmr, tmrNext;
  logic [7:0]       countReg, countNext;
  logic [5:0]       jamReg, jamNext;
  logic [AMT_W-1:0] remainingReg, remainingNext;
  logic             shortReg, shortNext;
  logic             abortLatch, abortNext;
  logic             abortNow;
  logic [5:0]       pickSel;
  logic [AMT_W-1:0] selValue;

  function automatic logic [AMT_W-1:0] coinValue(input int d);
    case (d)
      0:       return AMT_W'(5);
      1:       return AMT_W'(10);
      2:       return AMT_W'(25);
      3:       return AMT_W'(50);
      4:       return AMT_W'(100);
      default: return AMT_W'(500);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rem          <= '0;
      selReg       <= '0;
      tmr          <= '0;
      countReg     <= '0;
      jamReg       <= '0;
      remainingReg <= '0;
      shortReg     <= 1'b0;
      abortLatch   <= 1'b0;
    end else begin
      state        <= stateNext;
      rem          <= remNext;
      selReg       <= selNext;
      tmr          <= tmrNext;
      countReg     <= countNext;
      jamReg       <= jamNext;
      remainingReg <= remainingNext;
      shortReg     <= shortNext;
      abortLatch   <= abortNext;
    end
  end

  always_comb begin
    stateNext     = state;
    remNext       = rem;
    selNext       = selReg;
    tmrNext       = tmr;
    countNext     = countReg;
    jamNext       = jamReg;
    remainingNext = remainingReg;
    shortNext     = shortReg;
    abortNext     = abortLatch;
    abortNow      = abortLatch | bus.abort;
    pickSel       = '0;
    selValue      = '0;

    // Ascending scan so the largest eligible denomination wins.
    for (int d = 0; d < 6; d++) begin
      if (coinValue(d) <= rem && !bus.tubeEmpty[d] && !jamReg[d])
        pickSel = 6'(1 << d);
      if (selReg[d])
        selValue = coinValue(d);
    end

    if (state != IDLE)
      abortNext = abortNow;

    case (state)
      IDLE: begin
        if (bus.start) begin
          remNext       = bus.amount;
          countNext     = '0;
          jamNext       = '0;
          remainingNext = '0;
          shortNext     = 1'b0;
          abortNext     = 1'b0;
          stateNext     = SELECT;
        end
      end
      SELECT: begin
        if (abortNow || pickSel == 6'd0) begin
          stateNext = DONE;
        end else begin
          selNext   = pickSel;
          tmrNext   = ACK_LOAD;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (bus.coinAck) begin
          remNext   = rem - selValue;
          countNext = (countReg == 8'hFF) ? countReg : countReg + 8'd1;
          tmrNext   = GAP_LOAD;
          stateNext = GAP;
        end else if (tmr == '0) begin
          jamNext   = jamReg | selReg;
          tmrNext   = GAP_LOAD;
          stateNext = GAP;
        end else begin
          tmrNext = tmr - 1'b1;
        end
      end
      GAP: begin
        if (tmr == '0)
          stateNext = abortNow ? DONE : SELECT;
        else
          tmrNext = tmr - 1'b1;
      end
      DONE: begin
        remainingNext = rem;
        shortNext     = (rem != '0);
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.coinReq   = (state == REQ);
  assign bus.coinSel   = (state == REQ) ? selReg : 6'd0;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.shortfall = shortReg;
  assign bus.remaining = remainingReg;
  assign bus.coinCount = countReg;
  assign bus.jammed    = jamReg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout order, empty/jam skipping,
// abort, zero amount, start-while-busy and reset mid-transaction.
module tb_change_dispenser;
  localparam int AW  = 11;
  localparam int GAP = 4;
  localparam int ACK = 1000;

  localparam logic [5:0] NICKEL = 6'b000001;
  localparam logic [5:0] DIME   = 6'b000010;
  localparam logic [5:0] QUART  = 6'b000100;
  localparam logic [5:0] FIFTY  = 6'b001000;
  localparam logic [5:0] DOLLAR = 6'b010000;
  localparam logic [5:0] FIVE   = 6'b100000;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  change_dispenser_if #(.AMT_W(AW)) bus ();

  change_dispenser #(.AMT_W(AW), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic startTxn(input logic [AW-1:0] amt);
    bus.amount = amt;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic waitReq(output int n);
    n = 0;
    while (!bus.coinReq && n < 3000) begin
      step();
      n++;
    end
    if (!bus.coinReq) n = -1;
  endtask

  task automatic waitDone(output int n, output bit sawReq);
    n = 0;
    sawReq = 1'b0;
    while (!bus.done && n < 3000) begin
      step();
      n++;
      if (bus.coinReq) sawReq = 1'b1;
    end
    if (!bus.done) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if ({bus.coinReq, bus.coinSel, bus.busy, bus.done, bus.shortfall} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {bus.coinReq, bus.coinSel, bus.busy, bus.done, bus.shortfall});
    end
    vectors++;
    if ({bus.remaining, bus.coinCount, bus.jammed} !== 25'd0) begin
      errors++;
      $display("FAIL reset_status got %h want 0", {bus.remaining, bus.coinCount, bus.jammed});
    end
    rst_n = 1'b1;
    step();
  endtask

  // Every coin is acked two cycles after its request appears.
  task automatic test_payout(input string name, input logic [AW-1:0] amt, input logic [5:0] empty,
                             input int nCoins, input logic [35:0] seq,
                             input logic [AW-1:0] expRem, input logic expShort);
    int w;
    bit saw;
    logic [5:0] exp;
    bus.tubeEmpty = empty;
    startTxn(amt);
    vectors++;
    if (bus.busy !== 1'b1 || bus.coinReq !== 1'b0) begin
      errors++;
      $display("FAIL %s select_cycle busy=%b req=%b want busy=1 req=0", name, bus.busy, bus.coinReq);
    end
    for (int i = 0; i < nCoins; i++) begin
      exp = seq[6*i +: 6];
      waitReq(w);
      vectors++;
      if (w !== ((i == 0) ? 1 : GAP + 1)) begin
        errors++;
        $display("FAIL %s req_spacing[%0d] got %0d want %0d", name, i, w, (i == 0) ? 1 : GAP + 1);
      end
      vectors++;
      if (bus.coinSel !== exp) begin
        errors++;
        $display("FAIL %s coinSel[%0d] got %b want %b", name, i, bus.coinSel, exp);
      end
      step();
      step();
      vectors++;
      if (bus.coinReq !== 1'b1 || bus.coinSel !== exp) begin
        errors++;
        $display("FAIL %s req_hold[%0d] req=%b sel=%b want 1 %b", name, i, bus.coinReq, bus.coinSel, exp);
      end
      bus.coinAck = 1'b1;
      step();
      bus.coinAck = 1'b0;
    end
    waitDone(w, saw);
    vectors++;
    if (w !== GAP + 1 || saw !== 1'b0) begin
      errors++;
      $display("FAIL %s done_latency got %0d extraReq=%0d want %0d 0", name, w, saw, GAP + 1);
    end
    step();
    vectors++;
    if (bus.remaining !== expRem || bus.shortfall !== expShort || bus.coinCount !== 8'(nCoins)
        || bus.jammed !== 6'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result rem=%0d short=%b cnt=%0d jam=%b busy=%b want %0d %b %0d 000000 0",
               name, bus.remaining, bus.shortfall, bus.coinCount, bus.jammed, bus.busy,
               expRem, expShort, nCoins);
    end
    bus.tubeEmpty = 6'd0;
    step();
  endtask

  task automatic test_timeout();
    int w;
    int cnt;
    bit saw;
    startTxn(11'd100);
    waitReq(w);
    vectors++;
    if (w !== 1 || bus.coinSel !== DOLLAR) begin
      errors++;
      $display("FAIL timeout first_req wait=%0d sel=%b want 1 %b", w, bus.coinSel, DOLLAR);
    end
    cnt = 0;
    while (bus.coinReq && cnt < ACK + 10) begin
      cnt++;
      step();
    end
    vectors++;
    if (cnt !== ACK) begin
      errors++;
      $display("FAIL timeout req_len got %0d want %0d", cnt, ACK);
    end
    vectors++;
    if (bus.jammed !== DOLLAR) begin
      errors++;
      $display("FAIL timeout jammed got %b want %b", bus.jammed, DOLLAR);
    end
    for (int i = 0; i < 2; i++) begin
      waitReq(w);
      vectors++;
      if (w !== GAP + 1 || bus.coinSel !== FIFTY) begin
        errors++;
        $display("FAIL timeout fifty[%0d] wait=%0d sel=%b want %0d %b", i, w, bus.coinSel, GAP + 1, FIFTY);
      end
      step();
      step();
      bus.coinAck = 1'b1;
      step();
      bus.coinAck = 1'b0;
    end
    waitDone(w, saw);
    step();
    vectors++;
    if (w !== GAP + 1 || bus.remaining !== 11'd0 || bus.coinCount !== 8'd2 || bus.jammed !== DOLLAR) begin
      errors++;
      $display("FAIL timeout result wait=%0d rem=%0d cnt=%0d jam=%b want %0d 0 2 %b",
               w, bus.remaining, bus.coinCount, bus.jammed, GAP + 1, DOLLAR);
    end
    step();
  endtask

  task automatic test_abort();
    int w;
    bit saw;
    startTxn(11'd600);
    waitReq(w);
    vectors++;
    if (w !== 1 || bus.coinSel !== FIVE) begin
      errors++;
      $display("FAIL abort first_req wait=%0d sel=%b want 1 %b", w, bus.coinSel, FIVE);
    end
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    vectors++;
    if (bus.coinReq !== 1'b1) begin
      errors++;
      $display("FAIL abort req_kept got %b want 1", bus.coinReq);
    end
    bus.coinAck = 1'b1;
    step();
    bus.coinAck = 1'b0;
    waitDone(w, saw);
    vectors++;
    if (w !== GAP || saw !== 1'b0) begin
      errors++;
      $display("FAIL abort done_latency got %0d extraReq=%0d want %0d 0", w, saw, GAP);
    end
    step();
    vectors++;
    if (bus.remaining !== 11'd100 || bus.shortfall !== 1'b1 || bus.coinCount !== 8'd1) begin
      errors++;
      $display("FAIL abort result rem=%0d short=%b cnt=%0d want 100 1 1",
               bus.remaining, bus.shortfall, bus.coinCount);
    end
    step();
  endtask

  task automatic test_zero();
    startTxn(11'd0);
    vectors++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.coinReq !== 1'b0) begin
      errors++;
      $display("FAIL zero cycle1 busy=%b done=%b req=%b want 1 0 0", bus.busy, bus.done, bus.coinReq);
    end
    step();
    vectors++;
    if (bus.done !== 1'b1 || bus.coinReq !== 1'b0) begin
      errors++;
      $display("FAIL zero cycle2 done=%b req=%b want 1 0", bus.done, bus.coinReq);
    end
    step();
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.remaining !== 11'd0
        || bus.shortfall !== 1'b0 || bus.coinCount !== 8'd0) begin
      errors++;
      $display("FAIL zero cycle3 busy=%b done=%b rem=%0d short=%b cnt=%0d want 0 0 0 0 0",
               bus.busy, bus.done, bus.remaining, bus.shortfall, bus.coinCount);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int w;
    bit saw;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    startTxn(11'd10);
    waitReq(w);
    vectors++;
    if (w !== 1 || bus.coinSel !== DIME) begin
      errors++;
      $display("FAIL busy_start first_req wait=%0d sel=%b want 1 %b", w, bus.coinSel, DIME);
    end
    bus.amount = 11'd500;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.coinAck = 1'b1;
    step();
    bus.coinAck = 1'b0;
    waitDone(w, saw);
    step();
    vectors++;
    if (w !== GAP + 1 || saw !== 1'b0 || bus.coinCount !== 8'd1 || bus.remaining !== 11'd0
        || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start result wait=%0d extraReq=%0d cnt=%0d rem=%0d busy=%b want %0d 0 1 0 0",
               w, saw, bus.coinCount, bus.remaining, bus.busy, GAP + 1);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int w;
    bit sawDone;
    startTxn(11'd50);
    waitReq(w);
    vectors++;
    if (bus.coinSel !== FIFTY) begin
      errors++;
      $display("FAIL rst_mid req sel=%b want %b", bus.coinSel, FIFTY);
    end
    rst_n = 1'b0;
    step();
    vectors++;
    if ({bus.coinReq, bus.coinSel, bus.busy, bus.done, bus.shortfall, bus.remaining,
         bus.coinCount, bus.jammed} !== 34'd0) begin
      errors++;
      $display("FAIL rst_mid outputs req=%b sel=%b busy=%b done=%b cnt=%0d want all 0",
               bus.coinReq, bus.coinSel, bus.busy, bus.done, bus.coinCount);
    end
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done || bus.busy) sawDone = 1'b1;
    end
    vectors++;
    if (sawDone !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid activity_after_reset got %b want 0", sawDone);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.amount    = '0;
    bus.abort     = 1'b0;
    bus.tubeEmpty = 6'd0;
    bus.coinAck   = 1'b0;

    test_reset();
    test_payout("amt185", 11'd185, 6'b000000, 4, {12'd0, DIME, QUART, FIFTY, DOLLAR}, 11'd0, 1'b0);
    test_payout("amt100_nodollar", 11'd100, 6'b010000, 2, {24'd0, FIFTY, FIFTY}, 11'd0, 1'b0);
    test_payout("amt30_nosmall", 11'd30, 6'b000011, 1, {30'd0, QUART}, 11'd5, 1'b1);
    test_payout("amt17_odd", 11'd17, 6'b000000, 2, {24'd0, NICKEL, DIME}, 11'd2, 1'b1);
    test_timeout();
    test_abort();
    test_zero();
    test_back_to_back();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
